// File: rtl/rs_alloc_pkg.sv
// ---------------------------------------------------------------------------
// rs_alloc_pkg
// Shared sizing constants and types for the reservation-station entry
// allocator (rs_alloc_ctrl) and its bus interface.
//   RS_DEPTH   : number of managed entries
//   RS_ALLOC_W : allocation lanes per cycle
//   RS_FREE_W  : release lanes per cycle
//   RS_IDX_W   : entry index width
//   RS_CNT_W   : width of the free-entry counter (holds 0..RS_DEPTH)
// ---------------------------------------------------------------------------
package rs_alloc_pkg;

    localparam int RS_DEPTH   = 16;
    localparam int RS_ALLOC_W = 2;
    localparam int RS_FREE_W  = 2;
    localparam int RS_IDX_W   = $clog2(RS_DEPTH);
    localparam int RS_CNT_W   = $clog2(RS_DEPTH + 1);

    typedef logic [RS_IDX_W-1:0] rs_idx_t;
    typedef logic [RS_CNT_W-1:0] rs_cnt_t;

endpackage

// File: rtl/rs_alloc_ctrl_if.sv
// ---------------------------------------------------------------------------
// rs_alloc_ctrl_if
// Dispatch / issue-side bus of the entry allocator.
//   flush        : clear every entry (branch-mispredict recovery)
//   alloc_req    : per-lane allocation request (prefix-shaped)
//   alloc_ready  : per-lane "may allocate this cycle"
//   alloc_idx    : offered entry index per lane, lane 0 in the LSBs
//   free_valid   : per-lane release valid
//   free_idx     : released entry index per lane, lane 0 in the LSBs
//   free_cnt     : registered number of free entries
//   full / empty : free_cnt == 0 / free_cnt == DEPTH
//   err_dbl_free : sticky bad-release flag (0 unless checking is built in)
// master = dispatch/issue side, slave = allocator.
// ---------------------------------------------------------------------------
interface rs_alloc_ctrl_if
    import rs_alloc_pkg::*;
#(
    parameter int DEPTH       = RS_DEPTH,
    parameter int ALLOC_WIDTH = RS_ALLOC_W,
    parameter int FREE_WIDTH  = RS_FREE_W
) ();

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                         flush;
    logic [ALLOC_WIDTH-1:0]       alloc_req;
    logic [ALLOC_WIDTH-1:0]       alloc_ready;
    logic [ALLOC_WIDTH*IDX_W-1:0] alloc_idx;
    logic [FREE_WIDTH-1:0]        free_valid;
    logic [FREE_WIDTH*IDX_W-1:0]  free_idx;
    logic [CNT_W-1:0]             free_cnt;
    logic                         full;
    logic                         empty;
    logic                         err_dbl_free;

    modport master (
        output flush, alloc_req, free_valid, free_idx,
        input  alloc_ready, alloc_idx, free_cnt, full, empty, err_dbl_free
    );

    modport slave (
        input  flush, alloc_req, free_valid, free_idx,
        output alloc_ready, alloc_idx, free_cnt, full, empty, err_dbl_free
    );

endinterface

// File: rtl/msb_psel_gen.sv
// ---------------------------------------------------------------------------
// msb_psel_gen
// Multi-grant priority selector, MSB first. Grant slice k is the one-hot of
// the k-th highest set bit of req_i; slices with nothing left are all zero.
//   req_i     : WIDTH request bits
//   gnt_bus_o : REQS one-hot grant slices, slice 0 in the LSBs
// ---------------------------------------------------------------------------
module msb_psel_gen #(
    parameter int WIDTH = 16,
    parameter int REQS  = 2
) (
    input  logic [WIDTH-1:0]      req_i,
    output logic [REQS*WIDTH-1:0] gnt_bus_o
);

    logic [WIDTH-1:0] remaining;
    logic             found;

    // Each lane takes the highest request still standing and removes it so
    // the next lane sees the next one down.
    always_comb begin
        remaining = req_i;
        gnt_bus_o = '0;
        found     = 1'b0;
        for (int k = 0; k < REQS; k++) begin
            found = 1'b0;
            for (int b = WIDTH - 1; b >= 0; b--) begin
                if (!found && remaining[b]) begin
                    gnt_bus_o[k*WIDTH + b] = 1'b1;
                    remaining[b]           = 1'b0;
                    found                  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rs_alloc_ctrl_onehot_to_idx.sv
// ---------------------------------------------------------------------------
// onehot_to_idx
// One-hot to binary encoder. An all-zero input encodes to index 0.
//   onehot_i : WIDTH-bit one-hot (or zero) vector
//   idx_o    : binary position of the set bit
// ---------------------------------------------------------------------------
module onehot_to_idx #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot_i,
    output logic [IDX_W-1:0] idx_o
);

    // OR of the positions of every set bit; exact for a one-hot input.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// rs_alloc_ctrl
// Entry allocator for a DEPTH-entry table. Offers up to ALLOC_WIDTH free
// indices per cycle (highest index first), takes up to FREE_WIDTH releases
// per cycle, and clears everything on flush.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : rs_alloc_ctrl_if.slave (flush, alloc and release lanes, status)
// Optional build macro RS_ALLOC_DBL_FREE_CHK_EN: adds a sticky err_dbl_free
// flag and drops releases of non-busy or duplicated entries; without it the
// flag is tied low and releases are applied as given.
// ---------------------------------------------------------------------------
module rs_alloc_ctrl
    import rs_alloc_pkg::*;
#(
    parameter int DEPTH       = RS_DEPTH,
    parameter int ALLOC_WIDTH = RS_ALLOC_W,
    parameter int FREE_WIDTH  = RS_FREE_W
) (
    input logic            clock,
    input logic            reset_n,
    rs_alloc_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [CNT_W-1:0]             free_cnt_q, free_cnt_d;
    logic [ALLOC_WIDTH*DEPTH-1:0] gntBus;
    logic [ALLOC_WIDTH*IDX_W-1:0] allocIdx;
    logic [ALLOC_WIDTH-1:0]       allocReady;
    logic [ALLOC_WIDTH-1:0]       allocFire;
    logic [FREE_WIDTH-1:0]        freeApply;

    // Offers come from registered state only, so a release made this cycle
    // is not visible to the selector until the next one.
    msb_psel_gen #(
        .WIDTH (DEPTH),
        .REQS  (ALLOC_WIDTH)
    ) u_sel (
        .req_i     (~busy_q),
        .gnt_bus_o (gntBus)
    );

    for (genvar k = 0; k < ALLOC_WIDTH; k++) begin : g_lane
        onehot_to_idx #(
            .WIDTH (DEPTH),
            .IDX_W (IDX_W)
        ) u_enc (
            .onehot_i (gntBus[k*DEPTH +: DEPTH]),
            .idx_o    (allocIdx[k*IDX_W +: IDX_W])
        );

        // Lane k has a grant exactly when more than k entries are free.
        assign allocReady[k] = (free_cnt_q > CNT_W'(k)) && !bus.flush;
    end

    assign allocFire = bus.alloc_req & allocReady;

`ifdef RS_ALLOC_DBL_FREE_CHK_EN
    logic err_dbl_q, err_dbl_d;
    logic badFree;

    // A release is dropped and flagged when its entry is not busy or an
    // earlier lane already names the same entry; the first lane still wins.
    always_comb begin
        freeApply = '0;
        err_dbl_d = err_dbl_q;
        badFree   = 1'b0;
        for (int j = 0; j < FREE_WIDTH; j++) begin
            if (bus.free_valid[j] && !bus.flush) begin
                badFree = !busy_q[bus.free_idx[j*IDX_W +: IDX_W]];
                for (int m = 0; m < j; m++) begin
                    if (bus.free_valid[m] &&
                        (bus.free_idx[m*IDX_W +: IDX_W] == bus.free_idx[j*IDX_W +: IDX_W])) begin
                        badFree = 1'b1;
                    end
                end
                if (badFree) begin
                    err_dbl_d = 1'b1;
                end else begin
                    freeApply[j] = 1'b1;
                end
            end
        end
    end

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_dbl_q <= 1'b0;
        end else begin
            err_dbl_q <= err_dbl_d;
        end
    end

    assign bus.err_dbl_free = err_dbl_q;
`else
    assign freeApply        = bus.free_valid;
    assign bus.err_dbl_free = 1'b0;
`endif

    // Next busy map and count. Releases and allocations touch disjoint
    // entries for legal traffic; flush overrides both.
    always_comb begin
        int cntNext;
        busy_d  = busy_q;
        cntNext = 0;
        for (int j = 0; j < FREE_WIDTH; j++) begin
            if (freeApply[j]) begin
                busy_d[bus.free_idx[j*IDX_W +: IDX_W]] = 1'b0;
            end
        end
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            if (allocFire[k]) begin
                busy_d[allocIdx[k*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        cntNext = int'(free_cnt_q) - $countones(allocFire) + $countones(freeApply);
        if (cntNext < 0) begin
            cntNext = 0;
        end else if (cntNext > DEPTH) begin
            cntNext = DEPTH;
        end
        free_cnt_d = CNT_W'(cntNext);
        if (bus.flush) begin
            busy_d     = '0;
            free_cnt_d = CNT_W'(DEPTH);
        end
    end

    // State registers; reset frees every entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q     <= '0;
            free_cnt_q <= CNT_W'(DEPTH);
        end else begin
            busy_q     <= busy_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    assign bus.alloc_ready = allocReady;
    assign bus.alloc_idx   = allocIdx;
    assign bus.free_cnt    = free_cnt_q;
    assign bus.full        = (free_cnt_q == '0);
    assign bus.empty       = (free_cnt_q == CNT_W'(DEPTH));

endmodule
